// File: rtl/uart_rx_8n1.sv
// 8N1 asynchronous receiver: 16x oversampling with a 3-sample majority vote,
// one-entry valid/ready holding register, framing-error and overrun pulses.
module uart_rx_8n1 #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 1200
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic       ser_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
);

   localparam int              DIV  = CLK_HZ / (16 * BAUD);
   localparam int              TW   = $clog2(DIV);
   localparam logic [TW-1:0]   TMAX = TW'(DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    scnt_q, scnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          smp7_q, smp7_d, smp8_q, smp8_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          busy_q, busy_d;

   logic          rxs_s, tick_s, maj_s;
   logic [3:0]    scnt_now_s;
   logic          shift_s, stop_ok_s, stop_bad_s;

   assign rxs_s      = sync2_q;
   assign tick_s     = (tcnt_q == TMAX);
   // Decisions use the count this tick advances to, so the detecting tick is sample 0.
   assign scnt_now_s = scnt_q + 4'd1;
   assign maj_s      = (smp7_q & smp8_q) | (smp7_q & rxs_s) | (smp8_q & rxs_s);

   // FSM state register
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic, advancing only on oversample ticks
   always_comb begin
      state_d = state_q;
      if (tick_s) begin
         case (state_q)
            ST_IDLE: begin
               if (!rxs_s) state_d = ST_START;
               else        state_d = ST_IDLE;
            end
            ST_START: begin
               if ((scnt_now_s == 4'd9) && maj_s) state_d = ST_IDLE;
               else if (scnt_now_s == 4'd15)      state_d = ST_DATA;
               else                               state_d = ST_START;
            end
            ST_DATA: begin
               if ((scnt_now_s == 4'd15) && (bidx_q == 3'd7)) state_d = ST_STOP;
               else                                           state_d = ST_DATA;
            end
            ST_STOP: begin
               if (scnt_now_s == 4'd9) state_d = maj_s ? ST_IDLE : ST_BREAK;
               else                    state_d = ST_STOP;
            end
            ST_BREAK: begin
               if (rxs_s) state_d = ST_IDLE;
               else       state_d = ST_BREAK;
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // FSM outputs: data-bit shift and stop-bit verdict strobes
   always_comb begin
      shift_s    = 1'b0;
      stop_ok_s  = 1'b0;
      stop_bad_s = 1'b0;
      if (tick_s) begin
         case (state_q)
            ST_DATA: shift_s = (scnt_now_s == 4'd9);
            ST_STOP: begin
               stop_ok_s  = (scnt_now_s == 4'd9) &  maj_s;
               stop_bad_s = (scnt_now_s == 4'd9) & ~maj_s;
            end
            default: begin
               shift_s    = 1'b0;
               stop_ok_s  = 1'b0;
               stop_bad_s = 1'b0;
            end
         endcase
      end else begin
         shift_s    = 1'b0;
         stop_ok_s  = 1'b0;
         stop_bad_s = 1'b0;
      end
   end

   // Datapath next-state: counters, samples, shift register, holding register
   always_comb begin
      tcnt_d     = tick_s ? {TW{1'b0}} : (tcnt_q + TW'(1));
      scnt_d     = scnt_q;
      bidx_d     = bidx_q;
      smp7_d     = smp7_q;
      smp8_d     = smp8_q;
      shreg_d    = shreg_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      ovr_d      = 1'b0;
      ferr_d     = stop_bad_s;
      busy_d     = (state_d != ST_IDLE);

      if (tick_s) begin
         scnt_d = (state_q == ST_IDLE) ? 4'd0 : scnt_now_s;
         if (scnt_now_s == 4'd7) smp7_d = rxs_s;
         else                    smp7_d = smp7_q;
         if (scnt_now_s == 4'd8) smp8_d = rxs_s;
         else                    smp8_d = smp8_q;
         if (state_q == ST_START)                                bidx_d = 3'd0;
         else if ((state_q == ST_DATA) && (scnt_now_s == 4'd15)) bidx_d = bidx_q + 3'd1;
         else                                                    bidx_d = bidx_q;
      end else begin
         scnt_d = scnt_q;
      end

      if (shift_s) shreg_d = {maj_s, shreg_q[7:1]};
      else         shreg_d = shreg_q;

      // A completed byte may replace one being consumed on the same clock.
      if (stop_ok_s) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
   end

   // Datapath registers, including the input synchroniser
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         tcnt_q     <= {TW{1'b0}};
         scnt_q     <= 4'd0;
         bidx_q     <= 3'd0;
         smp7_q     <= 1'b1;
         smp8_q     <= 1'b1;
         shreg_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         sync1_q    <= ser_rx;
         sync2_q    <= sync1_q;
         tcnt_q     <= tcnt_d;
         scnt_q     <= scnt_d;
         bidx_q     <= bidx_d;
         smp7_q     <= smp7_d;
         smp8_q     <= smp8_d;
         shreg_q    <= shreg_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_overrun   = ovr_q;
   assign rx_busy      = busy_q;

endmodule
